// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH product in WIDTH RUN cycles.
// The add/subtract step is a ripple chain of full-adder cells; the controller registers all outputs.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH:0]    m_q;
  logic [WIDTH:0]    a_q;
  logic [WIDTH-1:0]  q_q;
  logic              q1_q;
  logic [CntW-1:0]   cnt_q;

  // Booth recode of {Q[0], q_1}
  logic do_add;
  logic do_sub;
  assign do_add = ~q_q[0] & q1_q;
  assign do_sub = q_q[0] & ~q1_q;

  // Ripple add/subtract: A + (M ^ {sub}) + sub, carry-out discarded
  logic [WIDTH:0] m_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] carry;

  assign m_x      = m_q ^ {(WIDTH + 1){do_sub}};
  assign carry[0] = do_sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign sum[i] = a_q[i] ^ m_x[i] ^ carry[i];
    if (i < WIDTH) begin : g_cout
      assign carry[i+1] = (a_q[i] & m_x[i]) | (carry[i] & (a_q[i] ^ m_x[i]));
    end
  end

  // Arithmetic right shift of {A', Q, q_1}
  logic [WIDTH:0]   a_sel;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic             q1_sh;

  always_comb begin
    a_sel = (do_add || do_sub) ? sum : a_q;
    a_sh  = {a_sel[WIDTH], a_sel[WIDTH:1]};
    q_sh  = {a_sel[0], q_q[WIDTH-1:1]};
    q1_sh = q_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            a_q     <= '0;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            cnt_q   <= CntW'(WIDTH);
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q   <= a_sh;
          q_q   <= q_sh;
          q1_q  <= q1_sh;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            product <= {a_sh[WIDTH-1:0], q_sh};
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
